sbox_pipe: RTL and testbench
============================

// Module: sbox_pipe
// PURPOSE
//  Parametrised, pipelined AES SubBytes engine: LANES independent byte S-box lookups per beat.
//  Sits between the AES round datapath (LANES=16) or key expansion SubWord (LANES=4) and the existing state regs.
//  Adds valid/ready flow control, back-pressure, a per-beat tag sideband and an optional inverse mode.
// PARAMETERS
//  LANES   4  bytes substituted per beat (1..16)
//  STAGES  2  register stages, input to output (1..4); STAGES = lookup latency in cycles
//  TAG_W   4  sideband tag width carried alongside data, unmodified (>=1)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          synchronous active-low reset
//  in_valid   in   1          input beat valid
//  in_ready   out  1          engine accepts beat this cycle
//  in_data    in   8*LANES    lane i = in_data[8i+7:8i]
//  in_tag     in   TAG_W      sideband, returned with result
//  in_inv     in   1          1 = inverse S-box for this beat (only with SBOX_INV_EN)
//  out_valid  out  1          result beat valid
//  out_ready  in   1          downstream accepts result
//  out_data   out  8*LANES    out lane i = S(in lane i) or InvS(in lane i)
//  out_tag    out  TAG_W      tag of the beat on out_data
//  occupancy  out  3          beats in flight, 0..STAGES
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-low: on clk edge with rst_n=0, all stage valid bits <= 0.
//    out_valid=0, out_data=0, out_tag=0, occupancy=0. in_ready=1 the first cycle after reset release.
//  - Transfer occurs on a rising edge where valid&&ready are both high, at the input and at the output.
//  - Pipeline: STAGES registers, each holding {valid, data, tag, inv}. Lookup is combinational,
//    registered in stage 0. Later stages carry the result.
//  - Stall rule per stage k: advance_k = !valid_k || advance_(k+1); advance_(last) = !out_valid || out_ready.
//    in_ready = advance_0 (combinational from out_ready; bubbles are collapsed).
//  - Latency: a beat accepted at edge N is on out_data after edge N+STAGES-1 when there is no stall.
//    Throughput is 1 beat/cycle when out_ready=1.
//  - A stalled stage holds its data/tag/valid stable. out_data/out_tag do not change while out_valid && !out_ready.
//  - Stage data is loaded only when the upstream beat is valid. Bubbles do not overwrite data (out_data holds its last value).
//  - occupancy = popcount(stage valid bits). Accept+emit in the same cycle leaves it unchanged.
//  - Full: all stages valid && !out_ready -> in_ready=0. An in_valid beat is held by the source and not lost.
//  - Empty: occupancy=0 -> out_valid=0.
//  - Reset mid-operation: all in-flight beats are discarded. No beat is emitted after reset.
//  - Tables: full 256-entry FIPS-197 forward S-box per lane (S(00)=63, S(53)=ed, S(ff)=16).
//    Lanes are fully independent; there is no cross-lane arithmetic.
//  - Parameter check: LANES outside 1..16 or STAGES outside 1..4 -> $error at elaboration.
// CONFIGURATION
//  SBOX_INV_EN defined: each lane also holds the FIPS-197 inverse table (InvS(63)=00, InvS(ed)=53, InvS(16)=ff).
//    in_inv is sampled with the beat (valid&&ready) and selects the table for all lanes of that beat.
//    Mixed fwd/inv beats may be back-to-back.
//  SBOX_INV_EN undefined: no inverse table is built. in_inv is ignored and every beat uses the forward table.
// TESTING
//  1 Reset: rst_n=0 for 3 clks with in_valid=1 -> out_valid=0, occupancy=0; in_ready=1 after release.
//  2 Basic (LANES=4, STAGES=2, out_ready=1): in_data=32'h0001_53ff, tag=4'h5 -> out_data=32'h637c_ed16.
//    It appears 2 cycles after accept with out_tag=4'h5.
//  3 Streaming: 256 beats, each with all lanes equal to i -> each out lane = S(i) in order with matching tags, 1 beat/cycle.
//  4 Back-pressure: out_ready=0 with 3 beats offered -> 2 accepted, occupancy=2, in_ready=0, out_data stable.
//    out_ready=1 -> both beats drain in order with no loss or duplication.
//  5 SBOX_INV_EN: beat 32'h6300_ed16 with in_inv=1, then the same beat with in_inv=0 -> 32'h0052_53ff, then 32'hfb63_5547.
//    Without the macro, both beats return 32'hfb63_5547.
//  6 Mid-flight reset: 2 beats in pipe, rst_n=0 for 1 clk -> no out_valid afterwards; the next beat 8'h00 lanes -> 8'h63.

Source files
------------

// File: rtl/sbox_pipe.sv
// Pipelined AES SubBytes engine: LANES independent byte S-box lookups per beat with valid/ready flow control.
// Define SBOX_INV_EN to add the per-beat inverse S-box selected by in_inv.
module sbox_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic [2:0]           occupancy
);

  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("sbox_pipe: LANES must be in 1..16");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("sbox_pipe: STAGES must be in 1..4");
  end

  // Row 0 of each table sits in the most significant bits, so entry x starts at bit 2047-8x.
  localparam logic [2047:0] FWD_TABLE = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  function automatic logic [7:0] fwd_sub(input logic [7:0] x);
    return FWD_TABLE[2047 - 8*int'(x) -: 8];
  endfunction

`ifdef SBOX_INV_EN
  localparam logic [2047:0] INV_TABLE = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  function automatic logic [7:0] inv_sub(input logic [7:0] x);
    return INV_TABLE[2047 - 8*int'(x) -: 8];
  endfunction
`else
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  logic [STAGES-1:0]  stage_valid;
  logic [8*LANES-1:0] stage_data [STAGES];
  logic [TAG_W-1:0]   stage_tag  [STAGES];
  logic [STAGES-1:0]  advance;
  logic [8*LANES-1:0] lut_data;

  always_comb begin
    lut_data = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef SBOX_INV_EN
      lut_data[8*i +: 8] = in_inv ? inv_sub(in_data[8*i +: 8]) : fwd_sub(in_data[8*i +: 8]);
`else
      lut_data[8*i +: 8] = fwd_sub(in_data[8*i +: 8]);
`endif
    end
  end

  // Stage k stalls only when it and every stage after it are full and the sink refuses.
  always_comb begin
    logic run_full;
    advance  = '0;
    run_full = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      run_full = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        run_full = run_full & stage_valid[j];
      end
      advance[k] = out_ready || !run_full;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_data[k] <= '0;
        stage_tag[k]  <= '0;
      end
    end else begin
      if (advance[0]) begin
        stage_valid[0] <= in_valid;
        if (in_valid) begin
          stage_data[0] <= lut_data;
          stage_tag[0]  <= in_tag;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (advance[k]) begin
          stage_valid[k] <= stage_valid[k-1];
          if (stage_valid[k-1]) begin
            stage_data[k] <= stage_data[k-1];
            stage_tag[k]  <= stage_tag[k-1];
          end
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + {2'b00, stage_valid[k]};
    end
  end

  assign in_ready  = advance[0];
  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[STAGES-1];
  assign out_tag   = stage_tag[STAGES-1];

endmodule

// File: tb/tb_sbox_pipe.sv
// Directed bench for sbox_pipe (LANES=4, STAGES=2, TAG_W=4); forward expectations come from a GF(2^8) model.
module tb_sbox_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        in_inv;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic [2:0]  occupancy;

  int n_compared;
  int n_mismatched;

  logic [7:0] model_s [256];

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        inv;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  sbox_pipe #(.LANES(4), .STAGES(2), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, a_l, b_l;
    logic hi;
    p = 8'h00;
    a_l = a;
    b_l = b;
    for (int i = 0; i < 8; i++) begin
      if (b_l[0]) p = p ^ a_l;
      hi  = a_l[7];
      a_l = a_l << 1;
      if (hi) a_l = a_l ^ 8'h1b;
      b_l = b_l >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Multiplicative inverse followed by the FIPS-197 affine transform.
  task automatic build_model();
    logic [7:0] inv_b;
    for (int a = 0; a < 256; a++) begin
      inv_b = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv_b = 8'(b);
      end
      model_s[a] = inv_b ^ rotl8(inv_b, 1) ^ rotl8(inv_b, 2) ^ rotl8(inv_b, 3) ^ rotl8(inv_b, 4) ^ 8'h63;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic [3:0] tag, input logic inv);
    in_valid = 1'b1;
    in_data  = data;
    in_tag   = tag;
    in_inv   = inv;
  endtask

  initial begin
    logic [31:0] exp_inv_a;
    logic [3:0]  exp_tag;
    n_compared   = 0;
    n_mismatched = 0;
    build_model();

    vecs[0] = '{32'h0001_53ff, 4'h5, 1'b0, 32'h637c_ed16};
`ifdef SBOX_INV_EN
    vecs[1] = '{32'h6300_ed16, 4'ha, 1'b1, 32'h0052_53ff};
    vecs[4] = '{32'hffff_ffff, 4'hf, 1'b1, 32'h7d7d_7d7d};
    exp_inv_a = 32'h0052_53ff;
`else
    vecs[1] = '{32'h6300_ed16, 4'ha, 1'b1, 32'hfb63_5547};
    vecs[4] = '{32'hffff_ffff, 4'hf, 1'b1, 32'h1616_1616};
    exp_inv_a = 32'hfb63_5547;
`endif
    vecs[2] = '{32'h6300_ed16, 4'h3, 1'b0, 32'hfb63_5547};
    vecs[3] = '{32'h0000_0000, 4'h0, 1'b0, 32'h6363_6363};
    vecs[5] = '{32'h0102_0304, 4'hc, 1'b0, 32'h7c77_7bf2};

    // Reset held for three clocks while the source keeps offering a beat.
    rst_n = 1'b0;
    out_ready = 1'b1;
    applyStimulus(32'h1234_5678, 4'h9, 1'b0);
    repeat (3) step();
    checkOutput("reset_valid_occ", {60'd0, out_valid, occupancy}, 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    checkOutput("reset_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset_data_tag", {28'd0, out_data, out_tag}, 64'd0);

    // Single beats: latency, tag return, drain and data hold after the beat leaves.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].data, vecs[v].tag, vecs[v].inv);
      step();
      in_valid = 1'b0;
      checkOutput($sformatf("vec%0d_in_flight", v), {60'd0, out_valid, occupancy}, {60'd0, 1'b0, 3'd1});
      step();
      checkOutput($sformatf("vec%0d_result", v), {27'd0, out_valid, out_data, out_tag},
                  {27'd0, 1'b1, vecs[v].exp_data, vecs[v].tag});
      step();
      checkOutput($sformatf("vec%0d_drained", v), {24'd0, out_valid, occupancy, out_data},
                  {24'd0, 1'b0, 3'd0, vecs[v].exp_data});
    end

    // 256 back-to-back beats, one result per cycle in order.
    for (int t = 0; t <= 256; t++) begin
      if (t < 256) applyStimulus({4{8'(t)}}, 4'(t), 1'b0);
      else in_valid = 1'b0;
      step();
      if (t >= 1) begin
        exp_tag = 4'(t - 1);
        checkOutput($sformatf("stream%0d", t - 1), {27'd0, out_valid, out_data, out_tag},
                    {27'd0, 1'b1, {4{model_s[t-1]}}, exp_tag});
      end
    end
    step();
    checkOutput("stream_empty", {60'd0, out_valid, occupancy}, 64'd0);

    // Back-pressure: three beats offered with the sink stalled.
    out_ready = 1'b0;
    applyStimulus(32'h0102_0304, 4'h1, 1'b0);
    step();
    applyStimulus(32'h1011_1213, 4'h2, 1'b0);
    step();
    applyStimulus(32'h2021_2223, 4'h3, 1'b0);
    checkOutput("bp_full", {60'd0, in_ready, occupancy}, {60'd0, 1'b0, 3'd2});
    step();
    checkOutput("bp_hold1", {24'd0, in_ready, occupancy, out_data}, {24'd0, 1'b0, 3'd2, 32'h7c77_7bf2});
    step();
    checkOutput("bp_hold2", {27'd0, out_valid, out_data, out_tag}, {27'd0, 1'b1, 32'h7c77_7bf2, 4'h1});
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("bp_drain_b", {27'd0, out_valid, out_data, out_tag}, {27'd0, 1'b1, 32'hca82_c97d, 4'h2});
    step();
    checkOutput("bp_drain_c", {27'd0, out_valid, out_data, out_tag}, {27'd0, 1'b1, 32'hb7fd_9326, 4'h3});
    step();
    checkOutput("bp_empty", {60'd0, out_valid, occupancy}, 64'd0);

    // Inverse beat immediately followed by a forward beat of the same data.
    applyStimulus(32'h6300_ed16, 4'h1, 1'b1);
    step();
    applyStimulus(32'h6300_ed16, 4'h2, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("mix_first", {27'd0, out_valid, out_data, out_tag}, {27'd0, 1'b1, exp_inv_a, 4'h1});
    step();
    checkOutput("mix_second", {27'd0, out_valid, out_data, out_tag}, {27'd0, 1'b1, 32'hfb63_5547, 4'h2});
    step();

    // Reset with two beats parked in the pipe.
    out_ready = 1'b0;
    applyStimulus(32'h5555_5555, 4'h4, 1'b0);
    step();
    applyStimulus(32'haaaa_aaaa, 4'h5, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("mr_loaded", {60'd0, out_valid, occupancy}, {60'd0, 1'b1, 3'd2});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("mr_cleared", {60'd0, out_valid, occupancy}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("mr_quiet%0d", i), {63'd0, out_valid}, 64'd0);
    end
    applyStimulus(32'h0000_0000, 4'h7, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    checkOutput("mr_next_beat", {27'd0, out_valid, out_data, out_tag}, {27'd0, 1'b1, 32'h6363_6363, 4'h7});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
